// File: rtl/alu_pkg.sv
// Purpose: shared op codes, FSM state codes and default width for the execute-stage ALU.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package alu_pkg;

  // Default operand / result-half width
  localparam int ALU_WIDTH = 16;

  // Op codes, shared with the upstream ALU control decoder
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;
  localparam logic [2:0] OP_SWP = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b111;

  // Execute FSM states; anything other than S_IDLE means an iterative op is in flight
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

endpackage

// File: rtl/muldiv_iter.sv
// Purpose: shared one-bit-per-cycle engine for unsigned shift-add multiply and restoring divide.
// Latency: WIDTH steps after load; next_lo/next_hi show the post-step value so the last step lands directly in the caller's registers.
// Backpressure: none; the caller stops stepping by deasserting step, and load restarts it.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             div_mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_lo,
  output logic [WIDTH-1:0] next_hi,
  output logic             last
);

  localparam int CW = $clog2(WIDTH) + 1;

  // {hi_q, lo_q} is the 2*WIDTH shift register:
  //   multiply: hi_q = partial product, lo_q = remaining multiplier bits
  //   divide:   hi_q = partial remainder, lo_q = dividend bits shifting into quotient
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem_sh;
  logic [WIDTH:0]   div_trial;

  // One iteration of the selected algorithm, computed from the current register contents
  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_rem_sh = {hi_q, lo_q[WIDTH-1]};
    div_trial  = div_rem_sh - {1'b0, b_q};
    next_lo    = lo_q;
    next_hi    = hi_q;
    if (mode_q) begin
      // Borrow out of the trial subtract means the divisor did not fit: restore.
      if (div_trial[WIDTH]) begin
        next_hi = div_rem_sh[WIDTH-1:0];
        next_lo = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        next_hi = div_trial[WIDTH-1:0];
        next_lo = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      // Conditional add then shift right, carry falls into the top of the product.
      next_hi = mul_sum[WIDTH:1];
      next_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // The step taken while the counter reads WIDTH-1 is the final one
  always_comb begin
    last = (cnt_q == CW'(WIDTH - 1));
  end

  // Load operands on accept, otherwise advance one bit per stepping cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= a;
      b_q    <= b;
      mode_q <= div_mode;
      cnt_q  <= '0;
    end else if (step) begin
      hi_q   <= next_hi;
      lo_q   <= next_lo;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Purpose: execute-stage ALU; add/sub/move/swap/nop in one cycle, iterative unsigned mult/div.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH cycles for mult/div.
// Backpressure: busy high while mult/div runs; start is ignored (not queued) while busy.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  logic [1:0]       state;
  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             div_zero;
  logic             iter_load;
  logic             iter_last;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;

  // Accept decode and the single-cycle arithmetic, one extra bit for carry/borrow
  always_comb begin
    accept    = start && (state == S_IDLE);
    is_mul    = (operation == OP_MUL);
    is_div    = (operation == OP_DIV);
    div_zero  = (b == '0);
    iter_load = accept && (is_mul || (is_div && !div_zero));
    add_sum   = {1'b0, a} + {1'b0, b};
    sub_diff  = {1'b0, a} - {1'b0, b};
  end

  assign busy = (state != S_IDLE);

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (iter_load),
    .div_mode (is_div),
    .step     (busy),
    .a        (a),
    .b        (b),
    .next_lo  (iter_lo),
    .next_hi  (iter_hi),
    .last     (iter_last)
  );

  // FSM plus output registers: done pulses for exactly one cycle per accepted op
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      result_lo   <= '0;
      result_hi   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        case (operation)
          OP_ADD: begin
            result_lo   <= add_sum[WIDTH-1:0];
            result_hi   <= {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
          OP_SUB: begin
            // Bit WIDTH of the extended difference is the unsigned borrow (a < b)
            result_lo   <= sub_diff[WIDTH-1:0];
            result_hi   <= {{(WIDTH-1){1'b0}}, sub_diff[WIDTH]};
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
          OP_MOV: begin
            result_lo   <= a;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
          OP_SWP: begin
            result_lo   <= b;
            result_hi   <= a;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
          OP_MUL: begin
            state <= S_MUL;
          end
          OP_DIV: begin
            // Zero divisor short-circuits: no iteration, flag raised, stay idle
            if (div_zero) begin
              result_lo   <= '1;
              result_hi   <= a;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              state <= S_DIV;
            end
          end
          default: begin
            // nop and undefined codes: complete without touching the result pair
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
        endcase
      end else if (busy && iter_last) begin
        result_lo   <= iter_lo;
        result_hi   <= iter_hi;
        div_by_zero <= 1'b0;
        done        <= 1'b1;
        state       <= S_IDLE;
      end
    end
  end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Execute-stage ALU directly downstream of the ALU control decoder.
- Consumes the 3-bit operation code plus two operands.
- Add, sub, move, swap and nop complete in one cycle. Multiply and divide are iterative, one bit per cycle.
- Results return on a lo/hi register pair with a done pulse. A start/busy handshake lets the issuing control logic stall.

Parameters:
- WIDTH, 16, operand and per-result-half width in bits (>= 4).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- operation  input  3  op code: 000 add, 001 sub, 010 mult, 011 div, 100 move, 101 swap, any other value nop (111 is the decoder's nop).
- a  input  WIDTH  operand A, captured at accepted start.
- b  input  WIDTH  operand B, captured at accepted start.
- result_lo  output  WIDTH  low result half (registered).
- result_hi  output  WIDTH  high result half (registered).
- done  output  1  one-cycle completion pulse.
- busy  output  1  high while an iterative op is in flight.
- div_by_zero  output  1  flag, valid alongside done.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE; result_lo, result_hi, done, busy, div_by_zero all go to 0.
  - Reset overrides start and aborts any in-flight mult/div; no done is produced for the aborted op.
- FSM states: IDLE, MUL, DIV. busy = (state != IDLE).
- Accept rule: start=1 and state=IDLE at edge E. start while busy=1 is ignored, neither queued nor errored.
- Single-cycle ops, accepted at E: results and done=1 are registered at E and visible in the next cycle (latency 1).
  - add: lo = a+b (mod 2^WIDTH); hi = carry-out, zero-extended.
  - sub: lo = a-b (mod 2^WIDTH); hi = borrow (1 when a<b, unsigned), zero-extended.
  - move: lo = a; hi = 0.
  - swap: lo = b; hi = a.
  - nop/undefined codes: done pulses; result_lo/result_hi keep their previous values; div_by_zero=0.
- mult (unsigned shift-add):
  - At E: load operands, clear the 2*WIDTH accumulator, enter MUL.
  - WIDTH iterations, one per cycle. At edge E+WIDTH: {hi,lo} = a*b, done=1, return to IDLE.
  - busy is high for exactly WIDTH cycles.
- div (unsigned restoring):
  - Same timing as mult. lo = quotient, hi = remainder.
  - If b==0 at accept: no iteration; at E, lo = all ones, hi = a, div_by_zero=1, done=1, stay IDLE (latency 1).
- div_by_zero is updated at every completion: 1 only for div-by-zero, else 0.
- done is high for exactly one cycle per accepted op and is never asserted otherwise.
- Back-to-back issue:
  - In the cycle done is high, state is IDLE, so a new start is accepted.
  - For single-cycle ops this gives one completion per cycle.
- Operands are captured at accept. Changes on a/b/operation while busy have no effect.
- result_lo/result_hi hold their value until the next completion (or reset).

Decomposition:
- Shared package alu_pkg:
  - op-code constants OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010, OP_DIV=3'b011, OP_MOV=3'b100, OP_SWP=3'b101, OP_NOP=3'b111;
  - FSM state constants S_IDLE, S_MUL, S_DIV;
  - default WIDTH.
  - The ALU control decoder uses the same op-code constants.
- One sub-module: muldiv_iter. It holds the shared 2*WIDTH shift register, the iteration counter and the add/subtract-per-step datapath, selected by a mode bit. The top holds the FSM, single-cycle ops and output registers.

Test Plan (WIDTH=16):
1. add a=0xFFFF, b=0x0001 -> next cycle done=1, lo=0x0000, hi=0x0001. Then sub a=0x0003, b=0x0005 issued in that done cycle -> next cycle lo=0xFFFE, hi=0x0001.
2. mult a=0x1234, b=0x5678 -> busy=1 for 16 cycles, done 16 cycles after accept, hi=0x0626, lo=0x0060, div_by_zero=0.
3. div a=100, b=7 -> done after 16 cycles, lo=0x000E, hi=0x0002. div a=0x1234, b=0 -> done next cycle, lo=0xFFFF, hi=0x1234, div_by_zero=1, busy never high.
4. swap a=0xAAAA, b=0x5555 -> lo=0x5555, hi=0xAAAA. Then operation=3'b111 and 3'b110 -> done pulses each, lo/hi unchanged.
5. mult started, then start=1 with add asserted 3 cycles later -> add ignored; only one done, carrying the mult result.
6. rst=1 at cycle 5 of a mult -> next cycle busy=0, done=0, lo=hi=0, div_by_zero=0. No done follows; a new add is accepted immediately after rst drops.
